key_conditioner: RTL and testbench



---
 rtl/clock_pkg.sv | 23 ++
 rtl/key_conditioner_if.sv | 10 +
 rtl/key_debounce_cell.sv | 113 +++++++++++
 rtl/key_conditioner.sv | 52 +++++
 tb/tb_key_conditioner.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared constants and key FSM encoding for the clock's key front-end.
// Timing defaults assume a 50 MHz clk.
package clock_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_t;

   localparam int DEBOUNCE_CYCLES = 1000000;
   localparam int REPEAT_DELAY    = 25000000;
   localparam int REPEAT_RATE     = 5000000;
   localparam int CNT_W           = 25;

   localparam int PLUS     = 0;
   localparam int MINUS    = 1;
   localparam int EDIT     = 2;
   localparam int SWI      = 3;
   localparam int NUM_KEYS = 4;

endpackage

// File: rtl/key_conditioner_if.sv
// One key channel: raw active-low level in, one-cycle active-low strobe and
// debounced pressed level out. The conditioning cell is the master.
interface key_conditioner_if;
   logic raw;
   logic key_n;
   logic held;

   modport master (input raw, output key_n, output held);
   modport slave  (output raw, input key_n, input held);
endinterface

// File: rtl/key_debounce_cell.sv
// Per-key synchroniser, debounce FSM, repeat counter and registered strobe.
// REPEAT_EN selects auto-repeat while the key stays held.
module key_debounce_cell
   import clock_pkg::*;
#(
   parameter bit REPEAT_EN       = 1'b0,
   parameter int DEBOUNCE_CYCLES = clock_pkg::DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = clock_pkg::REPEAT_DELAY,
   parameter int REPEAT_RATE     = clock_pkg::REPEAT_RATE,
   parameter int CNT_W           = clock_pkg::CNT_W
) (
   input logic                clk,
   input logic                reset,
   key_conditioner_if.master  kif
);

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic             sync1, sync2;
   key_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             first_rep, first_nx;
   logic             strobe_n, fire;
   logic [CNT_W-1:0] rep_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         state     <= RELEASED;
         cnt       <= '0;
         first_rep <= 1'b1;
         strobe_n  <= 1'b1;
      end else begin
         sync1     <= kif.raw;
         sync2     <= sync1;
         state     <= state_nx;
         cnt       <= cnt_nx;
         first_rep <= first_nx;
         strobe_n  <= ~fire;
      end
   end

   // first_rep picks the long initial delay until one repeat has fired
   assign rep_last = first_rep ? DELAY_LAST : RATE_LAST;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      first_nx = first_rep;
      fire     = 1'b0;
      case (state)
         RELEASED: begin
            cnt_nx = '0;
            if (!sync2) begin
               state_nx = PRESS_WAIT;
               cnt_nx   = CNT_ONE;
            end
         end
         PRESS_WAIT: begin
            if (sync2) begin
               state_nx = RELEASED;
               cnt_nx   = '0;
            end else if (cnt == DEB_LAST) begin
               state_nx = HELD;
               cnt_nx   = '0;
               first_nx = 1'b1;
               fire     = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         HELD: begin
            if (sync2) begin
               state_nx = RELEASE_WAIT;
               cnt_nx   = CNT_ONE;
            end else if (REPEAT_EN) begin
               if (cnt == rep_last) begin
                  cnt_nx   = '0;
                  first_nx = 1'b0;
                  fire     = 1'b1;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
         end
         RELEASE_WAIT: begin
            // a short high blip returns to HELD and restarts the repeat delay
            if (!sync2) begin
               state_nx = HELD;
               cnt_nx   = '0;
               first_nx = 1'b1;
            end else if (cnt == DEB_LAST) begin
               state_nx = RELEASED;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = RELEASED;
            cnt_nx   = '0;
         end
      endcase
   end

   assign kif.key_n = strobe_n;
   assign kif.held  = (state == HELD) || (state == RELEASE_WAIT);

endmodule

// File: rtl/key_conditioner.sv
// Conditions the four raw board pushbuttons into clean one-cycle strobes for
// the key-management stage. Plus/Minus auto-repeat; Edit/Swi do not.
module key_conditioner
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = clock_pkg::DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = clock_pkg::REPEAT_DELAY,
   parameter int REPEAT_RATE     = clock_pkg::REPEAT_RATE,
   parameter int CNT_W           = clock_pkg::CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RawPlus,
   input  logic       RawMinus,
   input  logic       RawEdit,
   input  logic       RawSwi,
   output logic       KeyPlus,
   output logic       KeyMinus,
   output logic       KeyEdit,
   output logic       KeySwi,
   output logic [3:0] KeyHeld
);

   key_conditioner_if kif [NUM_KEYS] ();

   assign kif[PLUS].raw  = RawPlus;
   assign kif[MINUS].raw = RawMinus;
   assign kif[EDIT].raw  = RawEdit;
   assign kif[SWI].raw   = RawSwi;

   assign KeyPlus  = kif[PLUS].key_n;
   assign KeyMinus = kif[MINUS].key_n;
   assign KeyEdit  = kif[EDIT].key_n;
   assign KeySwi   = kif[SWI].key_n;

   // keys are fully independent; downstream resolves simultaneous strobes
   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_cell #(
         .REPEAT_EN       ((i == PLUS) || (i == MINUS)),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE),
         .CNT_W           (CNT_W)
      ) u_cell (
         .clk   (clk),
         .reset (reset),
         .kif   (kif[i])
      );
      assign KeyHeld[i] = kif[i].held;
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short timing (debounce 4, delay 10, rate 3).
// A run-length model of the key rules is checked against the DUT every cycle.
module tb_key_conditioner;
   import clock_pkg::*;

   localparam int DEB  = 4;
   localparam int DLY  = 10;
   localparam int RATE = 3;
   localparam int CW   = 8;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] raw_tb = 4'hF;
   logic [3:0] key_n_v;
   logic [3:0] held_v;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   key_conditioner_if kb [4] ();

   for (genvar g = 0; g < 4; g++) begin : g_bus
      assign kb[g].raw  = raw_tb[g];
      assign kb[g].held = held_v[g];
      assign key_n_v[g] = kb[g].key_n;
   end

   key_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (DLY),
      .REPEAT_RATE     (RATE),
      .CNT_W           (CW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .RawPlus  (kb[0].raw),
      .RawMinus (kb[1].raw),
      .RawEdit  (kb[2].raw),
      .RawSwi   (kb[3].raw),
      .KeyPlus  (kb[0].key_n),
      .KeyMinus (kb[1].key_n),
      .KeyEdit  (kb[2].key_n),
      .KeySwi   (kb[3].key_n),
      .KeyHeld  (held_v)
   );

   // clock/reset block
   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // model: accepted level flips after DEB consecutive disagreeing samples;
   // while pressed, repeats fire DLY then every RATE samples of steady press
   bit         m_s1 [4];
   bit         m_s2 [4];
   bit         m_acc [4];
   int         m_run [4];
   int         m_since [4];
   int         m_due [4];
   logic [3:0] exp_key_n = 4'hF;
   logic [3:0] exp_held  = 4'h0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 4; k++) begin
            m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_acc[k] = 1'b0;
            m_run[k] = 0; m_since[k] = 0; m_due[k] = DLY;
         end
         exp_key_n = 4'hF;
         exp_held  = 4'h0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            bit pr;
            bit st;
            pr = !m_s2[k];
            st = 1'b0;
            if (pr != m_acc[k]) begin
               m_run[k]++;
               if (m_run[k] == DEB) begin
                  m_acc[k] = pr;
                  m_run[k] = 0;
                  if (pr) begin
                     st = 1'b1; m_since[k] = 0; m_due[k] = DLY;
                  end
               end
            end else begin
               if (m_acc[k] && m_run[k] > 0) begin
                  m_since[k] = 0; m_due[k] = DLY;
               end else if (m_acc[k] && (k == PLUS || k == MINUS)) begin
                  m_since[k]++;
                  if (m_since[k] == m_due[k]) begin
                     st = 1'b1; m_since[k] = 0; m_due[k] = RATE;
                  end
               end
               m_run[k] = 0;
            end
            exp_key_n[k] = !st;
            exp_held[k]  = m_acc[k];
            m_s2[k] = m_s1[k];
            m_s1[k] = raw_tb[k];
         end
      end
   end

   // scoreboard: per-cycle compare plus strobe statistics
   int dut_cnt [4];
   int exp_cnt [4];
   int t1 [4];
   int t2 [4];

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         check($sformatf("key_n[%0d]", k), int'(key_n_v[k]), int'(exp_key_n[k]));
         check($sformatf("held[%0d]", k), int'(held_v[k]), int'(exp_held[k]));
         if (!exp_key_n[k]) exp_cnt[k]++;
         if (!key_n_v[k]) begin
            dut_cnt[k]++;
            if (dut_cnt[k] == 1) t1[k] = cycle;
            else if (dut_cnt[k] == 2) t2[k] = cycle;
         end
      end
   end

   task automatic clear_stats();
      for (int k = 0; k < 4; k++) begin
         dut_cnt[k] = 0; exp_cnt[k] = 0; t1[k] = -1; t2[k] = -1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int c0;
   int r0;

   initial begin
      clear_stats();
      idle(2);
      check("reset_key_n", int'(key_n_v), 15);
      check("reset_held", int'(held_v), 0);
      #2 reset = 1'b1;
      idle(5);

      // clean Edit press, 20 cycles
      clear_stats();
      @(negedge clk); raw_tb[EDIT] = 1'b0; c0 = cycle;
      idle(20); raw_tb[EDIT] = 1'b1;
      idle(5);
      check("edit_held_before_accept", int'(held_v[EDIT]), 1);
      idle(1);
      check("edit_held_after_release", int'(held_v[EDIT]), 0);
      idle(10);
      check("edit_count", dut_cnt[EDIT], 1);
      check("edit_model_count", exp_cnt[EDIT], 1);
      check("edit_latency", t1[EDIT] - c0, 6);

      // Swi bounce: five 2-low/1-high bursts, then 10 low
      clear_stats();
      @(negedge clk); c0 = cycle;
      for (int i = 0; i < 5; i++) begin
         raw_tb[SWI] = 1'b0; idle(2);
         raw_tb[SWI] = 1'b1; idle(1);
      end
      raw_tb[SWI] = 1'b0; idle(10); raw_tb[SWI] = 1'b1;
      idle(12);
      check("swi_count", dut_cnt[SWI], 1);
      check("swi_latency", t1[SWI] - c0, 21);

      // Plus auto-repeat, 30 cycles held
      clear_stats();
      @(negedge clk); raw_tb[PLUS] = 1'b0; c0 = cycle;
      idle(30); raw_tb[PLUS] = 1'b1;
      idle(15);
      check("plus_count", dut_cnt[PLUS], 7);
      check("plus_model_count", exp_cnt[PLUS], 7);
      check("plus_first", t1[PLUS] - c0, 6);
      check("plus_second", t2[PLUS] - c0, 16);

      // Minus with a 2-cycle release blip
      clear_stats();
      @(negedge clk); raw_tb[MINUS] = 1'b0; c0 = cycle;
      idle(10); raw_tb[MINUS] = 1'b1;
      idle(2);  raw_tb[MINUS] = 1'b0;
      idle(2);
      check("minus_held_through_blip", int'(held_v[MINUS]), 1);
      idle(16); raw_tb[MINUS] = 1'b1;
      idle(15);
      check("minus_count", dut_cnt[MINUS], 4);
      check("minus_model_count", exp_cnt[MINUS], 4);
      check("minus_restart", t2[MINUS] - c0, 25);

      // Plus and Edit together
      clear_stats();
      @(negedge clk); raw_tb[PLUS] = 1'b0; raw_tb[EDIT] = 1'b0; c0 = cycle;
      idle(8); raw_tb[PLUS] = 1'b1; raw_tb[EDIT] = 1'b1;
      idle(12);
      check("simul_plus_t", t1[PLUS] - c0, 6);
      check("simul_edit_t", t1[EDIT] - c0, 6);
      check("simul_plus_count", dut_cnt[PLUS], 1);

      // reset while Plus is still debouncing
      clear_stats();
      @(negedge clk); raw_tb[PLUS] = 1'b0; c0 = cycle;
      idle(4);
      #2 reset = 1'b0;
      #1;
      check("rst_key_n", int'(key_n_v), 15);
      check("rst_held", int'(held_v), 0);
      idle(2);
      clear_stats();
      #2 reset = 1'b1; r0 = cycle;
      idle(8); raw_tb[PLUS] = 1'b1;
      idle(12);
      check("rst_plus_count", dut_cnt[PLUS], 1);
      check("rst_plus_latency", t1[PLUS] - r0, 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
